// File: rtl/uart_host_rx.sv
// rtl/uart_host_rx.sv - host-side 8N1 UART receiver with 16x oversampling and byte FIFO
//
// Decodes the serial stream on rx into bytes, buffers them in a
// first-word fall-through FIFO and reports sticky framing/overrun errors.
//
// Optional feature macro: UART_HOST_RX_PARITY_EN (8E1 frames plus parity_err).
//
// Ports:
//   clk        system clock, the only clock
//   rst        synchronous active-high reset
//   rx         serial line, idle high, asynchronous to clk
//   rd_en      pop the FIFO head (ignored while empty)
//   clr_err    clear sticky error flags (a same-cycle new error wins)
//   rd_data    FIFO head byte, valid while !empty
//   empty      FIFO empty
//   full       FIFO full
//   frame_err  sticky: stop bit sampled low
//   overrun    sticky: byte dropped because FIFO was full
//   parity_err sticky: parity mismatch (only with UART_HOST_RX_PARITY_EN)
module uart_host_rx #(
  parameter int BAUD_DIV = 4,
  parameter int FIFO_AW  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rd_en,
  input  logic       clr_err,
  output logic [7:0] rd_data,
  output logic       empty,
  output logic       full,
  output logic       frame_err,
  output logic       overrun
`ifdef UART_HOST_RX_PARITY_EN
  ,
  output logic       parity_err
`endif
);

  localparam int DW    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = FIFO_AW + 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_HOST_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_HIGH
  } state_t;

  state_t          state;
  logic            rx_m, rx_s, rx_d;
  logic [DW-1:0]   div_cnt;
  logic [3:0]      os_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]      count;

  logic tick, bit_end, stop_sample, wr_req, frame_set, do_rd, wr_ok;

  assign tick        = (div_cnt == DW'(BAUD_DIV - 1));
  assign bit_end     = tick && (os_cnt == 4'd15);
  assign stop_sample = (state == STOP) && bit_end;
  assign frame_set   = stop_sample && !rx_s;

`ifdef UART_HOST_RX_PARITY_EN
  logic par_bad, par_set;
  assign par_set = (state == PARITY) && bit_end && (rx_s != ^shreg);
  assign wr_req  = stop_sample && rx_s && !par_bad;
`else
  assign wr_req  = stop_sample && rx_s;
`endif

  // Receive FSM; the edge detector compares rx_s with its previous value rx_d.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rx_m    <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
      div_cnt <= '0;
      os_cnt  <= '0;
      bit_idx <= '0;
      shreg   <= '0;
`ifdef UART_HOST_RX_PARITY_EN
      par_bad <= 1'b0;
`endif
    end else begin
      rx_m    <= rx;
      rx_s    <= rx_m;
      rx_d    <= rx_s;
      div_cnt <= tick ? '0 : div_cnt + DW'(1);
      if (tick) os_cnt <= os_cnt + 4'd1;

      case (state)
        IDLE: begin
          if (!rx_s && rx_d) begin
            // Restart the divider so the start-bit centre is a fixed distance from the edge.
            state   <= START;
            os_cnt  <= '0;
            div_cnt <= '0;
          end
        end
        START: begin
          if (tick && os_cnt == 4'd7) begin
            if (!rx_s) begin
              state   <= DATA;
              os_cnt  <= '0;
              bit_idx <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end
        DATA: begin
          // os_cnt wraps 15 -> 0 by itself, so each bit is exactly 16 ticks.
          if (bit_end) begin
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_HOST_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
        end
`ifdef UART_HOST_RX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            par_bad <= (rx_s != ^shreg);
            state   <= STOP;
          end
        end
`endif
        STOP: begin
          if (bit_end) state <= rx_s ? IDLE : WAIT_HIGH;
        end
        WAIT_HIGH: begin
          // Hold off until the line is idle so a break is not decoded as 0x00 bytes.
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO: when full, a write is only accepted if the head is popped the same cycle.
  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_rd   = rd_en && !empty;
  assign wr_ok   = wr_req && (!full || rd_en);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_HOST_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      if (wr_ok) begin
        mem[wr_ptr] <= shreg;
        wr_ptr      <= wr_ptr + FIFO_AW'(1);
      end
      if (do_rd) rd_ptr <= rd_ptr + FIFO_AW'(1);
      count <= count + {{FIFO_AW{1'b0}}, wr_ok} - {{FIFO_AW{1'b0}}, do_rd};

      frame_err <= (frame_err && !clr_err) || frame_set;
      overrun   <= (overrun && !clr_err) || (wr_req && full && !rd_en);
`ifdef UART_HOST_RX_PARITY_EN
      parity_err <= (parity_err && !clr_err) || par_set;
`endif
    end
  end

endmodule

// File: tb/tb_uart_host_rx.sv
// tb/tb_uart_host_rx.sv - scoreboard bench for uart_host_rx
//
// Stimulus drives rx frames at 64 clocks/bit on the falling clock edge and
// pushes expected bytes into exp_q; a monitor pops and compares whenever
// the FIFO presents a byte and auto-reading is enabled.
module tb_uart_host_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       rd_en;
  logic       clr_err;
  logic [7:0] rd_data;
  logic       empty, full, frame_err, overrun;
`ifdef UART_HOST_RX_PARITY_EN
  logic       parity_err;
`endif

  logic stim_rd = 1'b0;
  logic mon_rd  = 1'b0;
  logic auto_rd = 1'b0;
  assign rd_en = stim_rd | mon_rd;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  uart_host_rx #(.BAUD_DIV(4), .FIFO_AW(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rd_en     (rd_en),
    .clr_err   (clr_err),
    .rd_data   (rd_data),
    .empty     (empty),
    .full      (full),
    .frame_err (frame_err),
    .overrun   (overrun)
`ifdef UART_HOST_RX_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called on a falling edge; one bit is 64 clocks.
  task automatic send_frame(input logic [7:0] d, input int low_stop_bits);
    rx = 1'b0;
    repeat (64) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (64) @(negedge clk);
    end
    if (low_stop_bits > 0) begin
      rx = 1'b0;
      repeat (64 * low_stop_bits) @(negedge clk);
    end
    rx = 1'b1;
    repeat (64) @(negedge clk);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !empty) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(name, {31'b0, (exp_q.size() == 0 && empty)}, 32'd1);
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    @(negedge clk);
  endtask

  // Monitor: pops one expected byte per FIFO entry presented.
  initial begin
    forever begin
      @(negedge clk);
      mon_rd = 1'b0;
      if (auto_rd && !rst && !empty) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_byte: got %0h expected none", rd_data);
        end else begin
          chk("fifo_byte", {24'b0, rd_data}, {24'b0, exp_q.pop_front()});
        end
        mon_rd = 1'b1;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int lat;
    rst     = 1'b1;
    rx      = 1'b1;
    clr_err = 1'b0;
    repeat (10) @(negedge clk);
    chk("reset_empty", {31'b0, empty}, 32'd1);
    chk("reset_full", {31'b0, full}, 32'd0);
    chk("reset_frame_err", {31'b0, frame_err}, 32'd0);
    chk("reset_overrun", {31'b0, overrun}, 32'd0);
    chk("reset_rd_data", {24'b0, rd_data}, 32'h00);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Single byte: write lands 611 clocks after the edge, empty seen low at that falling edge.
    lat = 0;
    fork
      send_frame(8'h55, 0);
      begin
        while (empty && lat < 800) begin
          @(negedge clk);
          lat++;
        end
      end
    join
    chk("single_latency_in_window", {31'b0, (lat >= 607 && lat <= 617)}, 32'd1);
    chk("single_data", {24'b0, rd_data}, 32'h55);
    stim_rd = 1'b1;
    @(negedge clk);
    stim_rd = 1'b0;
    chk("single_pop_empty", {31'b0, empty}, 32'd1);

    // Glitch shorter than half a bit: nothing written, no flags.
    auto_rd = 1'b1;
    rx = 1'b0;
    repeat (20) @(negedge clk);
    rx = 1'b1;
    repeat (700) @(negedge clk);
    chk("glitch_empty", {31'b0, empty}, 32'd1);
    chk("glitch_frame_err", {31'b0, frame_err}, 32'd0);
    chk("glitch_overrun", {31'b0, overrun}, 32'd0);
    exp_q.push_back(8'hc9);
    send_frame(8'hc9, 0);
    wait_drain("after_glitch_drain");

    // Framing error with a 3-bit-long low stop, then recovery.
    send_frame(8'ha3, 3);
    chk("framing_flag", {31'b0, frame_err}, 32'd1);
    chk("framing_empty", {31'b0, empty}, 32'd1);
    exp_q.push_back(8'h3c);
    send_frame(8'h3c, 0);
    wait_drain("after_framing_drain");
    chk("framing_sticky", {31'b0, frame_err}, 32'd1);
    pulse_clr();
    chk("framing_cleared", {31'b0, frame_err}, 32'd0);

    // Overrun: nine bytes, no reads; ninth is dropped.
    auto_rd = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      if (i <= 8) exp_q.push_back(8'(i));
      send_frame(8'(i), 0);
      if (i == 8) begin
        chk("full_after_8", {31'b0, full}, 32'd1);
        chk("no_overrun_after_8", {31'b0, overrun}, 32'd0);
      end
    end
    chk("overrun_after_9", {31'b0, overrun}, 32'd1);
    chk("full_after_9", {31'b0, full}, 32'd1);
    pulse_clr();
    chk("overrun_cleared", {31'b0, overrun}, 32'd0);

    // Full FIFO, rd_en on the stop-sample cycle of 0x77 (posedge 611 after the edge).
    fork
      send_frame(8'h77, 0);
      begin
        repeat (610) @(posedge clk);
        @(negedge clk);
        chk("head_at_simul_read", {24'b0, rd_data}, {24'b0, exp_q.pop_front()});
        stim_rd = 1'b1;
        @(negedge clk);
        stim_rd = 1'b0;
        chk("simul_full", {31'b0, full}, 32'd1);
        chk("simul_no_overrun", {31'b0, overrun}, 32'd0);
      end
    join
    exp_q.push_back(8'h77);
    auto_rd = 1'b1;
    wait_drain("final_drain");
    chk("final_overrun", {31'b0, overrun}, 32'd0);
    chk("final_full", {31'b0, full}, 32'd0);
    auto_rd = 1'b0;
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
